// File: rtl/regfile_port_arbiter_if.sv
// Bundle of core, debug and regfile-side signals around the regfile port arbiter.
interface regfile_port_arbiter_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 5;

    // Core pipeline read/write
    logic             core_rd_valid;
    logic             core_rd_ready;
    logic [IDX_W-1:0] core_rs1;
    logic [IDX_W-1:0] core_rs2;
    logic             core_resp_valid;
    logic [XLEN-1:0]  core_a;
    logic [XLEN-1:0]  core_b;
    logic             core_we;
    logic [IDX_W-1:0] core_wd_idx;
    logic [XLEN-1:0]  core_wd;

    // Debug port
    logic             dbg_valid;
    logic             dbg_we;
    logic [IDX_W-1:0] dbg_idx;
    logic [XLEN-1:0]  dbg_wdata;
    logic             dbg_ready;
    logic             dbg_resp_valid;
    logic [XLEN-1:0]  dbg_rdata;

    // Regfile side
    logic [IDX_W-1:0] rf_read_a;
    logic [IDX_W-1:0] rf_read_b;
    logic [IDX_W-1:0] rf_write_idx;
    logic [XLEN-1:0]  rf_data;
    logic             rf_write_enable;
    logic [XLEN-1:0]  rf_a;
    logic [XLEN-1:0]  rf_b;

    // Arbiter side
    modport slave (
        input  core_rd_valid, core_rs1, core_rs2, core_we, core_wd_idx, core_wd,
        input  dbg_valid, dbg_we, dbg_idx, dbg_wdata,
        input  rf_a, rf_b,
        output core_rd_ready, core_resp_valid, core_a, core_b,
        output dbg_ready, dbg_resp_valid, dbg_rdata,
        output rf_read_a, rf_read_b, rf_write_idx, rf_data, rf_write_enable
    );

    // Core/debug/regfile environment side
    modport master (
        output core_rd_valid, core_rs1, core_rs2, core_we, core_wd_idx, core_wd,
        output dbg_valid, dbg_we, dbg_idx, dbg_wdata,
        output rf_a, rf_b,
        input  core_rd_ready, core_resp_valid, core_a, core_b,
        input  dbg_ready, dbg_resp_valid, dbg_rdata,
        input  rf_read_a, rf_read_b, rf_write_idx, rf_data, rf_write_enable
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares the 2R/1W regfile between core and debug: core-priority arbitration with
// debug starvation protection, x0 forcing and same-cycle write bypass on read data.
module regfile_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_port_arbiter_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        CORE_PRI  = 1'b0,
        DBG_FORCE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             core_pend_q, core_pend_d;
    logic             dbg_pend_q, dbg_pend_d;
    logic             zero_a_q, zero_a_d;
    logic             zero_b_q, zero_b_d;
    logic             byp_a_q, byp_a_d;
    logic             byp_b_q, byp_b_d;
    logic [XLEN-1:0]  byp_data_q, byp_data_d;

    logic             core_ready;
    logic             dbg_rd_acc;
    logic             dbg_wr_acc;
    logic             dbg_ready;
    logic [IDX_W-1:0] read_a;
    logic [IDX_W-1:0] read_b;
    logic [IDX_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_data;
    logic             wr_en;
    logic [XLEN-1:0]  fix_a;
    logic [XLEN-1:0]  fix_b;

    // Arbitration, port muxing, starvation counter and response capture
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        core_ready = 1'b0;
        dbg_rd_acc = 1'b0;
        dbg_wr_acc = 1'b0;

        case (state_q)
            CORE_PRI: begin
                core_ready = 1'b1;
                dbg_rd_acc = bus.dbg_valid & ~bus.dbg_we & ~bus.core_rd_valid;
            end
            DBG_FORCE: begin
                core_ready = 1'b0;
                dbg_rd_acc = bus.dbg_valid & ~bus.dbg_we;
            end
            default: begin
                core_ready = 1'b0;
            end
        endcase

        dbg_wr_acc = bus.dbg_valid & bus.dbg_we & ~bus.core_we;
        dbg_ready  = dbg_rd_acc | dbg_wr_acc;

        // Debug read owns port A only when granted; port B always follows the core
        read_a  = dbg_rd_acc ? bus.dbg_idx : bus.core_rs1;
        read_b  = bus.core_rs2;

        wr_en   = bus.core_we | dbg_wr_acc;
        wr_idx  = bus.core_we ? bus.core_wd_idx : bus.dbg_idx;
        wr_data = bus.core_we ? bus.core_wd : bus.dbg_wdata;

        if (!bus.dbg_valid || dbg_ready) begin
            starve_d = '0;
        end else if (starve_q < CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        case (state_q)
            CORE_PRI: begin
                if (bus.dbg_valid && !dbg_ready && starve_d == CNT_W'(STARVE_MAX)) begin
                    state_d = DBG_FORCE;
                end
            end
            default: begin
                state_d = CORE_PRI;
            end
        endcase

        core_pend_d = bus.core_rd_valid & core_ready;
        dbg_pend_d  = dbg_rd_acc;
        zero_a_d    = (read_a == '0);
        zero_b_d    = (read_b == '0);
        byp_a_d     = wr_en && (wr_idx == read_a) && (wr_idx != '0);
        byp_b_d     = wr_en && (wr_idx == read_b) && (wr_idx != '0);
        byp_data_d  = wr_data;
    end

    // State and captured-response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CORE_PRI;
            starve_q    <= '0;
            core_pend_q <= 1'b0;
            dbg_pend_q  <= 1'b0;
            zero_a_q    <= 1'b0;
            zero_b_q    <= 1'b0;
            byp_a_q     <= 1'b0;
            byp_b_q     <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            core_pend_q <= core_pend_d;
            dbg_pend_q  <= dbg_pend_d;
            zero_a_q    <= zero_a_d;
            zero_b_q    <= zero_b_d;
            byp_a_q     <= byp_a_d;
            byp_b_q     <= byp_b_d;
            byp_data_q  <= byp_data_d;
        end
    end

    // Read data fix-ups: x0 first, then same-cycle write bypass, else regfile output
    always_comb begin
        fix_a = bus.rf_a;
        fix_b = bus.rf_b;
        if (zero_a_q) begin
            fix_a = '0;
        end else if (byp_a_q) begin
            fix_a = byp_data_q;
        end
        if (zero_b_q) begin
            fix_b = '0;
        end else if (byp_b_q) begin
            fix_b = byp_data_q;
        end
    end

    assign bus.core_rd_ready   = core_ready;
    assign bus.core_resp_valid = core_pend_q;
    assign bus.core_a          = fix_a;
    assign bus.core_b          = fix_b;
    assign bus.dbg_ready       = dbg_ready;
    assign bus.dbg_resp_valid  = dbg_pend_q;
    assign bus.dbg_rdata       = fix_a;
    assign bus.rf_read_a       = read_a;
    assign bus.rf_read_b       = read_b;
    assign bus.rf_write_idx    = wr_idx;
    assign bus.rf_data         = wr_data;
    assign bus.rf_write_enable = wr_en;

endmodule
